// File: rtl/encode_4_2_pri_seq_pkg.sv
// -----------------------------------------------------------------------------
// encode_4_2_pri_seq_pkg
// Shared definitions for the registered priority encoder with sticky pending
// requests:
//   - state_t : presentation FSM encoding (ST_IDLE = 1'b0, ST_PRES = 1'b1)
//   - ENC_N   : default number of request lines
//   - ENC_W   : default code width (log2 of ENC_N)
// -----------------------------------------------------------------------------
package encode_4_2_pri_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PRES = 1'b1
  } state_t;

  localparam int ENC_N = 4;
  localparam int ENC_W = 2;

endpackage : encode_4_2_pri_seq_pkg

// File: rtl/encode_4_2_pri_seq_pri_enc_comb.sv
// -----------------------------------------------------------------------------
// pri_enc_comb
// Purely combinational highest-index-wins priority encoder.
// Ports:
//   req  input  [N-1:0]  request vector (bit N-1 has highest priority)
//   idx  output [W-1:0]  index of the highest set bit (0 when none set)
//   any  output          at least one request bit is set
// -----------------------------------------------------------------------------
module pri_enc_comb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan upward so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx = req[k] ? W'(k) : idx;
    end
    any = |req;
  end

endmodule : pri_enc_comb

// File: rtl/encode_4_2_pri_seq.sv
// -----------------------------------------------------------------------------
// encode_4_2_pri_seq
// Registered priority encoder with sticky pending requests. Requests are
// captured into a pending register; the highest-index pending request is
// presented as a binary code with a valid/ack handshake and cleared when
// accepted. Every served code is followed by at least one V=0 cycle.
// Ports:
//   clk    input         rising-edge clock
//   rst_n  input         synchronous active-low reset
//   En     input         capture enable for new requests
//   I      input [N-1:0] request lines, level-sampled each clk
//   ack    input         consumer accepts the presented code
//   Y      output[W-1:0] encoded index of the presented request
//   V      output        Y is valid
//   pend   output[N-1:0] current pending register
//   ovf    output        (only with ENCODE_OVF_EN) sticky flag: a request
//                        arrived for a bit that was already pending
// Optional feature macro: ENCODE_OVF_EN
// -----------------------------------------------------------------------------
module encode_4_2_pri_seq
  import encode_4_2_pri_seq_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = ENC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         En,
  input  logic [N-1:0] I,
  input  logic         ack,
  output logic [W-1:0] Y,
  output logic         V,
  output logic [N-1:0] pend
`ifdef ENCODE_OVF_EN
  ,
  output logic         ovf
`endif
);

  state_t         state_r, state_nxt_s;
  logic [N-1:0]   pend_r, pend_nxt_s, set_s, clr_s;
  logic [W-1:0]   y_r, y_nxt_s, enc_s;
  logic           v_r, v_nxt_s, any_s;

  // One-hot mask selecting a single pending bit by its index.
  function automatic logic [N-1:0] idx_mask(input logic [W-1:0] idx);
    logic [N-1:0] m;
    m      = {N{1'b0}};
    m[idx] = 1'b1;
    return m;
  endfunction

  pri_enc_comb #(
    .N(N),
    .W(W)
  ) u_pri_enc (
    .req(pend_r),
    .idx(enc_s),
    .any(any_s)
  );

  // Pending update: set is applied after clear so a same-cycle re-request wins.
  always_comb begin
    set_s = {N{En}} & I;
    if ((state_r == ST_PRES) && ack) begin
      clr_s = idx_mask(y_r);
    end else begin
      clr_s = {N{1'b0}};
    end
    pend_nxt_s = (pend_r & ~clr_s) | set_s;
  end

  // Presentation FSM: the code is latched on leaving IDLE and held during PRES.
  always_comb begin
    state_nxt_s = state_r;
    y_nxt_s     = y_r;
    v_nxt_s     = v_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          y_nxt_s     = enc_s;
          v_nxt_s     = 1'b1;
          state_nxt_s = ST_PRES;
        end else begin
          v_nxt_s     = 1'b0;
        end
      end
      ST_PRES: begin
        if (ack) begin
          v_nxt_s     = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          v_nxt_s     = 1'b1;
        end
      end
      default: begin
        v_nxt_s     = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, pending and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pend_r  <= {N{1'b0}};
      y_r     <= {W{1'b0}};
      v_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      y_r     <= y_nxt_s;
      v_r     <= v_nxt_s;
    end
  end

  assign Y    = y_r;
  assign V    = v_r;
  assign pend = pend_r;

`ifdef ENCODE_OVF_EN
  logic ovf_r;

  // Sticky merge detector: uses pend_r before this edge's clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (|(set_s & pend_r));
    end
  end

  assign ovf = ovf_r;
`endif

endmodule : encode_4_2_pri_seq

// File: tb/tb_encode_4_2_pri_seq.sv
// -----------------------------------------------------------------------------
// tb_encode_4_2_pri_seq
// Directed and randomized stimulus for encode_4_2_pri_seq, checked against a
// cycle-level behavioural model of pending set, presentation and handshake.
// -----------------------------------------------------------------------------
module tb_encode_4_2_pri_seq;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         En = 1'b0;
  logic [N-1:0] I = 4'b0000;
  logic         ack = 1'b0;
  logic [W-1:0] Y;
  logic         V;
  logic [N-1:0] pend;
`ifdef ENCODE_OVF_EN
  logic         ovf;
`endif

  encode_4_2_pri_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .En   (En),
    .I    (I),
    .ack  (ack),
    .Y    (Y),
    .V    (V),
    .pend (pend)
`ifdef ENCODE_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  bit [N-1:0] m_pend = '0;
  bit         m_v    = 1'b0;
  int         m_y    = 0;
  bit         m_ovf  = 1'b0;
  int         codes[$];

  function automatic int highest(input bit [N-1:0] p);
    for (int k = N - 1; k >= 0; k--) begin
      if (p[k]) return k;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input bit r, input bit e, input bit [N-1:0] req, input bit a);
    bit [N-1:0] np;
    if (!r) begin
      m_pend = '0; m_v = 1'b0; m_y = 0; m_ovf = 1'b0;
    end else begin
      np = m_pend;
      if (m_v && a) np[m_y] = 1'b0;
      if (e) begin
        for (int k = 0; k < N; k++) begin
          if (req[k]) begin
            if (m_pend[k]) m_ovf = 1'b1;
            np[k] = 1'b1;
          end
        end
      end
      if (!m_v) begin
        if (m_pend != 0) begin
          m_y = highest(m_pend);
          m_v = 1'b1;
        end
      end else if (a) begin
        m_v = 1'b0;
      end
      m_pend = np;
    end
  endtask

  task automatic compare_all();
    check("pend", int'(pend), int'(m_pend));
    check("V", int'(V), int'(m_v));
    check("Y", int'(Y), m_y);
`ifdef ENCODE_OVF_EN
    check("ovf", int'(ovf), int'(m_ovf));
`endif
    if (V === 1'b1) codes.push_back(int'(Y));
  endtask

  task automatic step(input bit r, input bit e, input bit [N-1:0] req, input bit a);
    rst_n = r; En = e; I = req; ack = a;
    @(posedge clk);
    model_edge(r, e, req, a);
    #1;
    compare_all();
  endtask

  initial begin
    #1;
    // Reset with all requests active
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, 4'b1111, 1'b0);
      check("rst_pend", int'(pend), 0);
      check("rst_V", int'(V), 0);
      check("rst_Y", int'(Y), 0);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 4'b0000, 1'b0);
      check("post_rst_V", int'(V), 0);
    end

    // Single request
    step(1'b1, 1'b1, 4'b0100, 1'b0);
    check("single_pend", int'(pend), 4);
    check("single_V0", int'(V), 0);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("single_V", int'(V), 1);
    check("single_Y", int'(Y), 2);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("single_hold_Y", int'(Y), 2);
    step(1'b1, 1'b1, 4'b0000, 1'b1);
    check("single_ack_pend", int'(pend), 0);
    check("single_ack_V", int'(V), 0);
    check("single_Y_kept", int'(Y), 2);

    // Priority and ordering with ack held high
    codes.delete();
    step(1'b1, 1'b1, 4'b1011, 1'b1);
    for (int c = 0; c < 7; c++) step(1'b1, 1'b1, 4'b0000, 1'b1);
    check("prio_count", codes.size(), 3);
    if (codes.size() == 3) begin
      check("prio_0", codes[0], 3);
      check("prio_1", codes[1], 1);
      check("prio_2", codes[2], 0);
    end
    check("prio_pend", int'(pend), 0);

    // Hold stability
    step(1'b1, 1'b1, 4'b0001, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("hold_Y0", int'(Y), 0);
    step(1'b1, 1'b1, 4'b1000, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("hold_Y_stable", int'(Y), 0);
    check("hold_V", int'(V), 1);
    step(1'b1, 1'b1, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("hold_next_Y", int'(Y), 3);
    check("hold_next_V", int'(V), 1);
    step(1'b1, 1'b1, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 4'b0000, 1'b0);

    // Set-wins collision
    step(1'b1, 1'b1, 4'b0100, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    check("sw_Y", int'(Y), 2);
    step(1'b1, 1'b1, 4'b0100, 1'b1);
    check("sw_pend", int'(pend), 4);
    check("sw_V0", int'(V), 0);
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    check("sw_re_V", int'(V), 1);
    check("sw_re_Y", int'(Y), 2);
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b0);

    // En gating, merge and mid-presentation reset
    step(1'b1, 1'b0, 4'b0010, 1'b0);
    check("en_pend", int'(pend), 0);
    check("en_V", int'(V), 0);
    step(1'b1, 1'b1, 4'b0010, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    check("mid_V", int'(V), 1);
    check("mid_Y", int'(Y), 1);
    step(1'b1, 1'b1, 4'b0010, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b0);
`ifdef ENCODE_OVF_EN
    check("ovf_set", int'(ovf), 1);
`endif
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    check("mid_rst_V", int'(V), 0);
    check("mid_rst_pend", int'(pend), 0);
`ifdef ENCODE_OVF_EN
    check("ovf_rst", int'(ovf), 0);
`endif

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), 4'($urandom & $urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_encode_4_2_pri_seq
